// File: rtl/soc_system1_pll_pkg.sv
// Shared types and widths for the fabric PLL lock sequencer.
package soc_system1_pll_pkg;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/soc_system1_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module soc_system1_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_system1_pll_lock_sequencer.sv
// Drives PLL reset, qualifies lock and releases domain resets in order.
module soc_system1_pll_lock_sequencer
    import soc_system1_pll_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int NUM_DOMAINS         = 3,
    parameter int DOMAIN_STAGGER      = 8,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   soft_restart,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   all_ready,
    output logic                   fault,
    output logic [RETRY_W-1:0]     retry_cnt,
    output logic [LOSS_W-1:0]      lock_loss_cnt,
    output logic [2:0]             state_o
);

    localparam int REL_LEN = (NUM_DOMAINS - 1) * DOMAIN_STAGGER + 1;
    localparam int CNT_MAX = max2(max2(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES),
                                  max2(LOCK_TIMEOUT_CYCLES, REL_LEN));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [RETRY_W-1:0] retry_next;
    logic               locked_s;

    soc_system1_sync2 u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign cnt_inc    = cnt + 1'b1;
    assign retry_next = retry_cnt + 1'b1;
    assign state_o    = state;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= S_RESET_PLL;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            domain_rst    <= '1;
            all_ready     <= 1'b0;
            fault         <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else if (soft_restart) begin
            state      <= S_RESET_PLL;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            all_ready  <= 1'b0;
            fault      <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            unique case (state)
                S_RESET_PLL: begin
                    if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= S_STABILIZE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        retry_cnt <= retry_next;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        if (retry_next == RETRY_W'(MAX_RETRIES)) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= S_RESET_PLL;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_STABILIZE: begin
                    if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state         <= S_RELEASE;
                        cnt           <= '0;
                        domain_rst[0] <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!locked_s) begin
                        state      <= S_RESET_PLL;
                        cnt        <= '0;
                        pll_rst    <= 1'b1;
                        domain_rst <= '1;
                        all_ready  <= 1'b0;
                        if (lock_loss_cnt != '1)
                            lock_loss_cnt <= lock_loss_cnt + 1'b1;
                    end else if (state == S_RELEASE) begin
                        cnt <= cnt_inc;
                        // bit k drops once k*DOMAIN_STAGGER cycles have elapsed
                        for (int k = 1; k < NUM_DOMAINS; k++) begin
                            if (cnt_inc == CNT_W'(k * DOMAIN_STAGGER))
                                domain_rst[k] <= 1'b0;
                        end
                        if (cnt_inc == CNT_W'(REL_LEN)) begin
                            state      <= S_RUN;
                            cnt        <= '0;
                            all_ready  <= 1'b1;
                            domain_rst <= '0;
                        end
                    end
                end
                S_FAULT: begin
                    pll_rst    <= 1'b1;
                    domain_rst <= '1;
                    fault      <= 1'b1;
                end
                default: begin
                    state      <= S_RESET_PLL;
                    cnt        <= '0;
                    pll_rst    <= 1'b1;
                    domain_rst <= '1;
                    all_ready  <= 1'b0;
                    fault      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_system1_pll_lock_sequencer.sv
// Bench for the PLL lock sequencer: directed scenarios plus random lock traffic.
module tb_soc_system1_pll_lock_sequencer;

    localparam int HOLD   = 4;
    localparam int STABLE = 8;
    localparam int TO     = 32;
    localparam int ND     = 3;
    localparam int STAG   = 2;
    localparam int MAXR   = 2;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          soft_restart = 1'b0;
    logic          pll_rst;
    logic [ND-1:0] domain_rst;
    logic          all_ready;
    logic          fault;
    logic [3:0]    retry_cnt;
    logic [7:0]    lock_loss_cnt;
    logic [2:0]    state_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // phase codes: 0 reset_pll, 1 wait, 2 stabilize, 3 release, 4 run, 5 fault
    int ph = 0;
    int el = 0;
    int m_retry = 0;
    int m_loss = 0;
    bit s1 = 1'b0;
    bit s2 = 1'b0;

    always #5 refclk = ~refclk;

    soc_system1_pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (HOLD),
        .LOCK_STABLE_CYCLES  (STABLE),
        .LOCK_TIMEOUT_CYCLES (TO),
        .NUM_DOMAINS         (ND),
        .DOMAIN_STAGGER      (STAG),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .soft_restart  (soft_restart),
        .pll_rst       (pll_rst),
        .domain_rst    (domain_rst),
        .all_ready     (all_ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .state_o       (state_o)
    );

    task automatic lose_lock();
        ph = 0;
        el = 0;
        if (m_loss < 255) m_loss++;
    endtask

    task automatic model_edge();
        bit ls;
        ls = s2;
        s2 = s1;
        s1 = pll_locked;
        if (rst) begin
            ph = 0; el = 0; m_retry = 0; m_loss = 0; s1 = 0; s2 = 0;
        end else if (soft_restart) begin
            ph = 0; el = 0; m_retry = 0;
        end else begin
            case (ph)
                0: if (el + 1 == HOLD) begin ph = 1; el = 0; end else el++;
                1: begin
                    if (ls) begin
                        ph = 2; el = 0;
                    end else if (el + 1 == TO) begin
                        m_retry++;
                        ph = (m_retry == MAXR) ? 5 : 0;
                        el = 0;
                    end else el++;
                end
                2: begin
                    if (!ls) begin ph = 1; el = 0; end
                    else if (el + 1 == STABLE) begin ph = 3; el = 0; end
                    else el++;
                end
                3: begin
                    if (!ls) lose_lock();
                    else begin
                        el++;
                        if (el == (ND - 1) * STAG + 1) begin ph = 4; el = 0; end
                    end
                end
                4: if (!ls) lose_lock();
                default: ;
            endcase
        end
    endtask

    function automatic logic [ND-1:0] exp_dom();
        logic [ND-1:0] d;
        for (int k = 0; k < ND; k++)
            d[k] = (ph == 3) ? (el < k * STAG) : (ph != 4);
        return d;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        cyc++;
        check("state", 8'(state_o), 8'(ph));
        check("pll_rst", 8'(pll_rst), 8'(ph == 0 || ph == 5));
        check("domain_rst", 8'(domain_rst), 8'(exp_dom()));
        check("all_ready", 8'(all_ready), 8'(ph == 4));
        check("fault", 8'(fault), 8'(ph == 5));
        check("retry_cnt", 8'(retry_cnt), 8'(m_retry));
        check("lock_loss_cnt", lock_loss_cnt, 8'(m_loss));
    endtask

    task automatic wait_state(input string tag, input int s, input int budget);
        int n;
        n = 0;
        while (32'(state_o) != s && n < budget) begin
            step();
            n++;
        end
        check(tag, 8'(state_o), 8'(s));
    endtask

    initial begin
        int run;
        run = 0;
        for (int i = 0; i < 3; i++) step();
        check("rst_pll_rst", 8'(pll_rst), 8'd1);
        check("rst_domain", 8'(domain_rst), 8'h7);

        // normal bring-up, edges counted from the last reset edge
        rst = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            step();
            if (n == 6) pll_locked = 1'b1;
            case (n)
                3:  check("bringup_pll_rst_hi", 8'(pll_rst), 8'd1);
                4:  check("bringup_pll_rst_lo", 8'(pll_rst), 8'd0);
                16: check("bringup_dom16", 8'(domain_rst), 8'h7);
                17: check("bringup_dom17", 8'(domain_rst), 8'h6);
                19: check("bringup_dom19", 8'(domain_rst), 8'h4);
                21: check("bringup_dom21", 8'(domain_rst), 8'h0);
                22: check("bringup_ready", 8'(all_ready), 8'd1);
                default: ;
            endcase
        end

        // lock glitch while stabilizing
        soft_restart = 1'b1;
        step();
        soft_restart = 1'b0;
        wait_state("glitch_reach_stab", 2, 40);
        for (int i = 0; i < 4; i++) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_state("glitch_back_wait", 1, 10);
        wait_state("glitch_run", 4, 60);
        check("glitch_retry", 8'(retry_cnt), 8'd0);

        // lock loss in RUN, then persistent timeout into FAULT
        pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("loss_domain", 8'(domain_rst), 8'h7);
        check("loss_pll_rst", 8'(pll_rst), 8'd1);
        check("loss_ready", 8'(all_ready), 8'd0);
        check("loss_cnt", lock_loss_cnt, 8'd1);
        for (int i = 0; i < 80; i++) step();
        check("timeout_fault", 8'(fault), 8'd1);
        check("timeout_retry", 8'(retry_cnt), 8'd2);
        check("timeout_domain", 8'(domain_rst), 8'h7);

        // recovery from FAULT
        pll_locked = 1'b1;
        soft_restart = 1'b1;
        step();
        soft_restart = 1'b0;
        check("recover_fault", 8'(fault), 8'd0);
        check("recover_state", 8'(state_o), 8'd0);
        wait_state("recover_run", 4, 60);

        // rst in the middle of RELEASE
        soft_restart = 1'b1;
        step();
        soft_restart = 1'b0;
        wait_state("midrel_release", 3, 60);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrel_state", 8'(state_o), 8'd0);
        check("midrel_domain", 8'(domain_rst), 8'h7);
        check("midrel_loss", lock_loss_cnt, 8'd0);
        wait_state("midrel_run", 4, 60);

        // random lock traffic with occasional restarts and resets
        for (int i = 0; i < 2000; i++) begin
            if (run == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                run = pll_locked ? int'($urandom_range(1, 80))
                                 : int'($urandom_range(1, 45));
            end
            run--;
            soft_restart = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 699) == 0);
            step();
        end
        rst = 1'b0;
        soft_restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
